// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite to native memory bus bridge:
// response codes, bridge FSM states and the read/write grant encoding.
package axil_pkg;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    MEM_WR,
    MEM_RD,
    B_RESP,
    R_RESP
  } bridge_state_t;

  typedef enum logic {
    GNT_RD,
    GNT_WR
  } grant_t;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding register for an AXI-Lite request channel.
// Captures on valid && ready; the full flag is dropped by i_clear.
module axil_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;
  logic             w_full_next;

  // Clear only happens while full, so it never coincides with a capture.
  assign w_capture   = i_valid && r_ready;
  assign w_full_next = i_clear ? 1'b0 : (w_capture ? 1'b1 : r_full);

  // ready is registered as !full so it stays low during reset and rises
  // one edge after release; otherwise it tracks !full exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_full  <= w_full_next;
      r_ready <= !w_full_next;
      if (w_capture) r_data <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/axil_native_bridge.sv
// AXI-Lite slave that turns each read or write into a single native
// valid/ready memory transaction, with round-robin arbitration and timeout.
module axil_native_bridge
  import axil_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arprot,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output bridge_state_t         o_dbg_state
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  // Handshake rule on every channel: a beat transfers at a rising edge where
  // valid and ready are both high; valid never waits on ready.
  bridge_state_t                r_state;
  grant_t                       r_rr_last;
  logic                         r_mem_valid;
  logic [ADDR_WIDTH-1:0]        r_mem_addr;
  logic [DATA_WIDTH-1:0]        r_mem_wdata;
  logic [STRB_WIDTH-1:0]        r_mem_wstrb;
  logic                         r_bvalid;
  logic [1:0]                   r_bresp;
  logic                         r_rvalid;
  logic [1:0]                   r_rresp;
  logic [DATA_WIDTH-1:0]        r_rdata;
  logic [TMO_W-1:0]             r_tmo_cnt;

  logic                         w_aw_full, w_w_full, w_ar_full;
  logic [ADDR_WIDTH-1:0]        w_aw_addr, w_ar_addr;
  logic [DATA_WIDTH-1:0]        w_w_data;
  logic [STRB_WIDTH-1:0]        w_w_strb;
  logic                         w_wr_elig, w_rd_elig, w_grant_wr;
  logic                         w_tmo_hit, w_wr_done, w_rd_done;
  logic                         w_unused;

  assign w_unused = ^{s_awprot, s_arprot};

  axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk(clk), .rst(rst), .i_valid(s_awvalid), .o_ready(s_awready),
    .i_data(s_awaddr), .i_clear(w_wr_done), .o_full(w_aw_full), .o_data(w_aw_addr)
  );

  axil_hold_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
    .clk(clk), .rst(rst), .i_valid(s_wvalid), .o_ready(s_wready),
    .i_data({s_wdata, s_wstrb}), .i_clear(w_wr_done), .o_full(w_w_full),
    .o_data({w_w_data, w_w_strb})
  );

  axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk(clk), .rst(rst), .i_valid(s_arvalid), .o_ready(s_arready),
    .i_data(s_araddr), .i_clear(w_rd_done), .o_full(w_ar_full), .o_data(w_ar_addr)
  );

  assign w_wr_elig  = w_aw_full && w_w_full;
  assign w_rd_elig  = w_ar_full;
  assign w_grant_wr = w_wr_elig && (!w_rd_elig || (r_rr_last == GNT_RD));
  assign w_tmo_hit  = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);
  // mem_ready wins over a timeout landing in the same cycle.
  assign w_wr_done  = (r_state == MEM_WR) && (mem_ready || w_tmo_hit);
  assign w_rd_done  = (r_state == MEM_RD) && (mem_ready || w_tmo_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_last   <= GNT_RD;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= AXIL_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= AXIL_OKAY;
      r_rdata     <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (w_grant_wr) begin
            r_state     <= MEM_WR;
            r_rr_last   <= GNT_WR;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= w_aw_addr & ~LOW_MASK;
            r_mem_wdata <= w_w_data;
            r_mem_wstrb <= w_w_strb;
          end else if (w_rd_elig) begin
            r_state     <= MEM_RD;
            r_rr_last   <= GNT_RD;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= w_ar_addr & ~LOW_MASK;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
          end
        end
        MEM_WR: begin
          if (w_wr_done) begin
            r_state     <= B_RESP;
            r_mem_valid <= 1'b0;
            r_bvalid    <= 1'b1;
            r_bresp     <= mem_ready ? AXIL_OKAY : AXIL_SLVERR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        MEM_RD: begin
          if (w_rd_done) begin
            r_state     <= R_RESP;
            r_mem_valid <= 1'b0;
            r_rvalid    <= 1'b1;
            r_rresp     <= mem_ready ? AXIL_OKAY : AXIL_SLVERR;
            r_rdata     <= mem_ready ? mem_rdata : '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        B_RESP: begin
          if (s_bready) begin
            r_state  <= IDLE;
            r_bvalid <= 1'b0;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            r_state  <= IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_bvalid    = r_bvalid;
  assign s_bresp     = r_bresp;
  assign s_rvalid    = r_rvalid;
  assign s_rresp     = r_rresp;
  assign s_rdata     = r_rdata;
  assign mem_valid   = r_mem_valid;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axil_native_bridge.sv
// Directed bench for axil_native_bridge: vector table plus hand-written
// sequences for latency, skew, arbitration, timeout and reset corners.
module tb_axil_native_bridge;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 1 + AW + DW + SW;

  logic          clk, rst;
  logic          s_awvalid, s_awready;
  logic [AW-1:0] s_awaddr;
  logic [2:0]    s_awprot;
  logic          s_wvalid, s_wready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_bvalid, s_bready;
  logic [1:0]    s_bresp;
  logic          s_arvalid, s_arready;
  logic [AW-1:0] s_araddr;
  logic [2:0]    s_arprot;
  logic          s_rvalid, s_rready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;
  bridge_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_mem_done = 0;
  int mem_lat = 0;
  bit mem_never = 0;
  logic [DW-1:0] rd_value = '0;
  logic [EW-1:0] exp_q[$];

  axil_native_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Native memory responder and scoreboard
  initial begin
    int wait_cnt;
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    wait_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && !mem_never && !rst) begin
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rd_value;
          wait_cnt = 0;
          n_mem_done++;
          if (exp_q.size() == 0) begin
            check("mem_unexpected_txn", {mem_addr, mem_wstrb}, '0);
          end else begin
            e = exp_q.pop_front();
            act = {e[EW-1], mem_addr, (e[EW-1] ? mem_wdata : '0), mem_wstrb};
            check("mem_txn", act, e);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_cnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic send_aw(input logic [AW-1:0] addr);
    int cnt = 0;
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_awprot = 3'($urandom_range(0, 7));
    while (!s_awready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) check("aw_accept_timeout", 0, 1);
    @(posedge clk); #1 s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int cnt = 0;
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
    while (!s_wready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) check("w_accept_timeout", 0, 1);
    @(posedge clk); #1 s_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] addr);
    int cnt = 0;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = addr; s_arprot = 3'($urandom_range(0, 7));
    while (!s_arready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) check("ar_accept_timeout", 0, 1);
    @(posedge clk); #1 s_arvalid = 1'b0;
  endtask

  task automatic wait_b(input string name, input logic [1:0] exp_resp);
    int cnt = 0;
    while (!s_bvalid && cnt < 100) begin @(negedge clk); cnt++; end
    if (cnt >= 100) check({name, "_bvalid_timeout"}, 0, 1);
    else begin
      check({name, "_bresp"}, s_bresp, exp_resp);
      s_bready = 1'b1;
      @(posedge clk); #1 s_bready = 1'b0;
    end
  endtask

  task automatic wait_r(input string name, input logic [1:0] exp_resp, input logic [DW-1:0] exp_data);
    int cnt = 0;
    while (!s_rvalid && cnt < 100) begin @(negedge clk); cnt++; end
    if (cnt >= 100) check({name, "_rvalid_timeout"}, 0, 1);
    else begin
      check({name, "_rresp"}, s_rresp, exp_resp);
      check({name, "_rdata"}, s_rdata, exp_data);
      s_rready = 1'b1;
      @(posedge clk); #1 s_rready = 1'b0;
    end
  endtask

  function automatic logic [EW-1:0] wr_rec(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic [SW-1:0] s);
    return {1'b1, a, d, s};
  endfunction

  function automatic logic [EW-1:0] rd_rec(input logic [AW-1:0] a);
    return {1'b0, a, {DW{1'b0}}, {SW{1'b0}}};
  endfunction

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] mem_rd;
    logic          never;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cnt;
    int done0;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 32'h0000_0010, AXIL_OKAY, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0023, 32'h5566_7788, 4'h3, 32'h0, 1'b0, 32'h0000_0020, AXIL_OKAY, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0041, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 32'h0000_0040, AXIL_OKAY, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 32'h8000_0006, 32'h0102_0304, 4'h8, 32'h0, 1'b1, 32'h8000_0004, AXIL_SLVERR, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 32'hFFFF_FFFC, AXIL_OKAY, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h7777_7777, 1'b1, 32'h0000_0100, AXIL_SLVERR, 32'h0};
    vecs[6] = '{1'b1, 32'h7FFF_FFFC, 32'h0000_0000, 4'h1, 32'h0, 1'b0, 32'h7FFF_FFFC, AXIL_OKAY, 32'h0};

    s_awvalid = 0; s_awaddr = '0; s_awprot = '0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_arvalid = 0; s_araddr = '0; s_arprot = '0;
    s_bready = 0; s_rready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mem_valid", mem_valid, 0);
    check("reset_resp_valids", {s_bvalid, s_rvalid}, 0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_readies", {s_awready, s_wready, s_arready}, 3'b111);

    // Write with AW and W together, zero-wait memory: exact cycle timing
    mem_lat = 0;
    exp_q.push_back(wr_rec(32'h1004, 32'hDEAD_BEEF, 4'hF));
    fork
      send_aw(32'h1004);
      send_w(32'hDEAD_BEEF, 4'hF);
    join
    @(negedge clk);
    check("wr1_mem_valid_e0", mem_valid, 0);
    @(negedge clk);
    check("wr1_mem_valid_e1", mem_valid, 1);
    check("wr1_mem_addr", mem_addr, 32'h1004);
    check("wr1_mem_wstrb", mem_wstrb, 4'hF);
    @(negedge clk);
    check("wr1_mem_valid_e2", mem_valid, 0);
    check("wr1_bvalid_e2", s_bvalid, 1);
    wait_b("wr1", AXIL_OKAY);

    // Read with 3-cycle memory latency and stalled R channel
    mem_lat = 2; rd_value = 32'hCAFE_F00D;
    exp_q.push_back(rd_rec(32'h0000_0300));
    send_ar(32'h0000_0300);
    cnt = 0;
    while (!s_rvalid && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) check("rd_lat_rvalid_timeout", 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rd_lat_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, AXIL_OKAY, 32'hCAFE_F00D});
    end
    wait_r("rd_lat", AXIL_OKAY, 32'hCAFE_F00D);
    mem_lat = 0;

    // Skewed write: W first, AW five cycles later
    done0 = n_mem_done;
    exp_q.push_back(wr_rec(32'h2000, 32'h0BAD_CAFE, 4'h5));
    send_w(32'h0BAD_CAFE, 4'h5);
    @(negedge clk);
    check("skew_wready_low", s_wready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("skew_no_mem", mem_valid, 0);
    end
    send_aw(32'h2002);
    wait_b("skew", AXIL_OKAY);
    repeat (3) @(negedge clk);
    check("skew_one_txn", n_mem_done - done0, 1);

    // Write and read pending together, twice: grants alternate read, write
    for (int r = 0; r < 2; r++) begin
      done0 = n_mem_done;
      rd_value = 32'h5000_0000 + 32'(r);
      exp_q.push_back(rd_rec(32'h0000_4000));
      exp_q.push_back(wr_rec(32'h0000_5000, 32'h6000_0000 + 32'(r), 4'hC));
      fork
        send_aw(32'h0000_5000);
        send_w(32'h6000_0000 + 32'(r), 4'hC);
        send_ar(32'h0000_4000);
      join
      wait_r("arb_rd", AXIL_OKAY, 32'h5000_0000 + 32'(r));
      wait_b("arb_wr", AXIL_OKAY);
      repeat (4) @(negedge clk);
      check("arb_txn_count", n_mem_done - done0, 2);
      check("arb_sb_drain", exp_q.size(), 0);
      check("arb_no_extra_resp", {s_bvalid, s_rvalid}, 0);
    end

    // Timeout: memory never answers
    mem_never = 1;
    send_ar(32'h0000_6000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) cnt++;
    end
    check("tmo_mem_valid_cycles", cnt, 4);
    wait_r("tmo", AXIL_SLVERR, 32'h0);
    mem_never = 0;
    rd_value = 32'h0000_ABCD;
    exp_q.push_back(rd_rec(32'h0000_6004));
    send_ar(32'h0000_6004);
    wait_r("tmo_after", AXIL_OKAY, 32'h0000_ABCD);

    // mem_ready in the last timeout cycle wins
    mem_lat = 3; rd_value = 32'h0F0F_0F0F;
    exp_q.push_back(rd_rec(32'h0000_7008));
    send_ar(32'h0000_7008);
    wait_r("tmo_edge", AXIL_OKAY, 32'h0F0F_0F0F);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      mem_lat = i % 3;
      mem_never = vecs[i].never;
      rd_value = vecs[i].mem_rd;
      if (!vecs[i].never)
        exp_q.push_back(vecs[i].is_wr ? wr_rec(vecs[i].exp_addr, vecs[i].wdata, vecs[i].wstrb)
                                      : rd_rec(vecs[i].exp_addr));
      if (vecs[i].is_wr) begin
        fork
          send_aw(vecs[i].addr);
          send_w(vecs[i].wdata, vecs[i].wstrb);
        join
        wait_b("vec_wr", vecs[i].exp_resp);
      end else begin
        send_ar(vecs[i].addr);
        wait_r("vec_rd", vecs[i].exp_resp, vecs[i].exp_rdata);
      end
      repeat (2) @(negedge clk);
      check("vec_sb_drain", exp_q.size(), 0);
    end
    mem_never = 0;
    mem_lat = 0;

    // Reset while a write is on the native bus
    mem_never = 1;
    fork
      send_aw(32'h0000_3000);
      send_w(32'h1357_9BDF, 4'hF);
    join
    @(negedge clk);
    @(negedge clk);
    check("rst_in_mem_wr", dbg_state, MEM_WR);
    #2 rst = 1'b1;
    #1;
    check("rst_async_mem", {mem_valid, mem_addr, mem_wdata, mem_wstrb}, '0);
    check("rst_async_readies", {s_awready, s_wready, s_arready}, 3'b000);
    check("rst_async_resp", {s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata}, '0);
    @(negedge clk);
    rst = 1'b0;
    mem_never = 0;
    s_bready = 1'b1;
    #1;
    check("rst_release_readies_low", {s_awready, s_wready, s_arready}, 3'b000);
    @(negedge clk);
    check("rst_release_readies_high", {s_awready, s_wready, s_arready}, 3'b111);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_bvalid || mem_valid) cnt++;
    end
    check("rst_no_response", cnt, 0);
    check("rst_state_idle", dbg_state, IDLE);
    s_bready = 1'b0;
    rd_value = 32'h2468_ACE0;
    exp_q.push_back(rd_rec(32'h0000_0800));
    send_ar(32'h0000_0802);
    wait_r("post_rst_rd", AXIL_OKAY, 32'h2468_ACE0);
    repeat (3) @(negedge clk);
    check("final_sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
